unified_memory: RTL and testbench
=================================

Name: unified_memory

Overview:
- Parametrised successor to the single-port instruction memory.
- One memory array serves two ports:
  - a read-only fetch port (i_*);
  - a load/store data port (d_*) with byte, half and word access, sign/zero extension, and alignment/range faults.
- Read latency is configurable, with a valid-tracking response pipeline.
- Sits between the core's fetch and memory stages and the backing RAM.

Parameters:
- START_ADDR, 32'h01000000, byte address of the first memory word.
- DEPTH_BYTES, 1048576, memory size in bytes; must be a multiple of 4.
- READ_LATENCY, 1, cycles from request to response; legal values 1 or 2.
- MEM_PATH, "mem.hex", $readmemh init file for the word array.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  fetch request this cycle
- i_address  in  32  fetch byte address
- i_rvalid  out  1  fetch response valid
- i_data_out  out  32  fetched word
- i_fault  out  1  fetch fault (misaligned or out of range)
- d_valid  in  1  data request this cycle
- d_address  in  32  data byte address
- d_read_write  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- d_data_in  in  32  store data; low-order bits used
- d_rvalid  out  1  data response valid (loads and stores)
- d_data_out  out  32  load result; 0 for stores and faults
- d_fault  out  1  data fault

Behaviour:
- Reset:
  - Asynchronous, active low.
  - All *_rvalid, *_fault and *_data_out go to 0; the response pipeline is cleared.
  - Memory contents are not reset.
  - Responses pending when reset asserts are dropped and never emitted.
- Handshake:
  - No backpressure; a request is accepted every cycle its valid is high.
  - Response appears exactly READ_LATENCY cycles later and is held for one cycle.
  - Back-to-back requests give back-to-back responses, in order.
- Addressing: offset = address - START_ADDR, word index = offset >> 2.
- In range means address >= START_ADDR and offset < DEPTH_BYTES.
- Fetch faults when out of range or address[1:0] != 0.
- Data port faults when any of:
  - out of range;
  - half access with address[0] = 1;
  - word access with address[1:0] != 0;
  - d_size = 11.
- Faulting requests:
  - never write memory;
  - return rvalid = 1, fault = 1, data_out = 0.
- Store:
  - Byte lanes are selected by address[1:0] and size.
  - Store data is the low byte or half of d_data_in, shifted into the lane.
  - Unselected bytes are unchanged.
  - Memory is updated at the accepting edge.
- Load:
  - The word is read at the accepting edge.
  - The lane is extracted and extended per d_unsigned; word loads ignore d_unsigned.
- Ordering:
  - Load in cycle N+1 after a store in cycle N to the same word returns the new data.
  - Load and store are never in the same cycle (single data port).
- READ_LATENCY = 2: one extra register stage holds data, fault and valid, in both ports, after the array read.

Optional Feature:
- Macro FETCH_BYPASS_EN controls same-cycle fetch and store to the same word index.
- Defined: the fetch returns the merged post-store word.
- Undefined: the fetch returns the pre-store word (read-before-write).

Decomposition:
- Package mem_pkg holds:
  - size encodings MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_W;
  - default START_ADDR;
  - a fault-check function;
  - a load-extend function.
- Sub-module mem_lane_align (combinational):
  - generates byte enables and the shifted store word from address[1:0] and size;
  - extracts and extends load data.
  - Instantiated once for the store path and once for the load path.

Test Plan:
- Reset and fetch: assert reset_n = 0 mid-response, release, fetch 0x01000000 with word 0 = 0xDEADBEEF.
  -> No response is emitted for the pre-reset request; i_rvalid rises READ_LATENCY cycles after the post-reset request, with i_data_out = 0xDEADBEEF.
- Byte load sign extension: store byte 0x80 to 0x01000003, then load it signed, then unsigned.
  -> Signed load: d_data_out = 0xFFFFFF80. Unsigned load: 0x00000080. Other bytes of the word are unchanged.
- Half store: store half 0x1234 to 0x01000006 over 0xAAAAAAAA, then load the word at 0x01000004.
  -> d_data_out = 0x1234AAAA.
- Faults: each of the following -> fault = 1, data_out = 0, memory unchanged:
  - half access at 0x01000001;
  - word access at 0x01000002;
  - d_size = 11;
  - fetch at START_ADDR - 4;
  - load at START_ADDR + DEPTH_BYTES.
- Same-cycle fetch and store to 0x01000010 (old 0x11111111, store word 0x22222222).
  -> i_data_out = 0x22222222 with FETCH_BYPASS_EN defined, 0x11111111 without; a fetch on the next cycle returns 0x22222222 in both builds.
- Streaming: READ_LATENCY = 2, ten back-to-back fetches at 0x01000000 + 4k.
  -> Ten consecutive i_rvalid pulses, in order, starting 2 cycles after the first request, with correct words.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for unified_memory and its lane aligner:
//   - mem_size_e       : access size encodings (byte / half / word / illegal)
//   - MEM_START_ADDR   : default byte address of the first memory word
//   - mem_access_fault : range + alignment + size legality check
//   - mem_load_extend  : lane extraction and sign/zero extension for loads
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10,
    MEM_SIZE_X = 2'b11   // reserved encoding, always faults
  } mem_size_e;

  localparam logic [31:0] MEM_START_ADDR = 32'h0100_0000;

  // True when the access must be rejected: outside [base, base+depth),
  // misaligned for its size, or an illegal size code. The offset compare
  // is done after subtraction so base+depth may sit at the top of the map.
  function automatic logic mem_access_fault(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth,
                                            input mem_size_e   size);
    logic [31:0] off;
    logic        bad;
    off = addr - base;
    bad = (addr < base) || (off >= depth);
    case (size)
      MEM_SIZE_B: bad = bad;
      MEM_SIZE_H: bad = bad | addr[0];
      MEM_SIZE_W: bad = bad | (addr[1:0] != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pull the addressed byte/half out of a word and extend it.
  // Word loads return the word untouched regardless of zero_ext.
  function automatic logic [31:0] mem_load_extend(input logic [31:0] word,
                                                  input logic [1:0]  offset,
                                                  input mem_size_e   size,
                                                  input logic        zero_ext);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = 8'(word >> {offset, 3'b000});
    lane_h = 16'(word >> {offset[1], 4'b0000});
    case (size)
      MEM_SIZE_B: return zero_ext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      MEM_SIZE_H: return zero_ext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default:    return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering between a 32-bit memory word and a
// byte/half/word access at a given byte offset.
// Ports:
//   i_offset     in  2   address[1:0] of the access
//   i_size       in  2   access size (mem_size_e encoding)
//   i_unsigned   in  1   1 = zero-extend loads, 0 = sign-extend
//   i_store_data in  32  store data, low-order bits used
//   i_load_word  in  32  word read from the array
//   o_byte_en    out 4   byte enables for a store (0 for illegal size)
//   o_store_word out 32  store data shifted into its lane
//   o_load_data  out 32  extracted and extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_data
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_byte_en    = 4'b0000;
    o_store_word = 32'h0;
    case (mem_size_e'(i_size))
      MEM_SIZE_B: begin
        o_byte_en    = 4'b0001 << i_offset;
        o_store_word = {24'h0, i_store_data[7:0]} << {i_offset, 3'b000};
      end
      MEM_SIZE_H: begin
        o_byte_en    = 4'b0011 << i_offset;
        o_store_word = {16'h0, i_store_data[15:0]} << {i_offset, 3'b000};
      end
      MEM_SIZE_W: begin
        o_byte_en    = 4'b1111;
        o_store_word = i_store_data;
      end
      default: ;
    endcase
  end

  assign o_load_data = mem_load_extend(i_load_word, i_offset, mem_size_e'(i_size), i_unsigned);

endmodule

// File: rtl/unified_memory.sv
// -----------------------------------------------------------------------------
// unified_memory
// One word array shared by a read-only fetch port (i_*) and a load/store
// data port (d_*). Both ports are accepted every cycle their valid is high
// and answer READ_LATENCY (1 or 2) cycles later with a one-cycle response.
// Optional build macro:
//   FETCH_BYPASS_EN  defined   : a fetch hitting the word being stored in
//                                the same cycle returns the merged new word
//                    undefined : that fetch returns the old word
// Ports:
//   clock, reset_n                     clock, async active-low reset
//   i_valid/i_address                  fetch request
//   i_rvalid/i_data_out/i_fault        fetch response
//   d_valid/d_address/d_read_write/
//   d_size/d_unsigned/d_data_in        data request (1 = store)
//   d_rvalid/d_data_out/d_fault        data response (loads and stores)
// MEM_PATH names the preload image handed to the memory-init flow.
// -----------------------------------------------------------------------------
module unified_memory
  import mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR   = MEM_START_ADDR,
  parameter int unsigned DEPTH_BYTES  = 1048576,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       MEM_PATH     = "mem.hex"
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_valid,
  input  logic [31:0] i_address,
  output logic        i_rvalid,
  output logic [31:0] i_data_out,
  output logic        i_fault,
  input  logic        d_valid,
  input  logic [31:0] d_address,
  input  logic        d_read_write,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_data_in,
  output logic        d_rvalid,
  output logic [31:0] d_data_out,
  output logic        d_fault
);

  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if ((DEPTH_BYTES % 4) != 0 || DEPTH_BYTES == 0) begin : g_bad_depth
    $error("unified_memory: DEPTH_BYTES must be a non-zero multiple of 4");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("unified_memory: READ_LATENCY must be 1 or 2");
  end
  if (MEM_PATH == "") begin : g_no_image
    $error("unified_memory: MEM_PATH must name a preload image");
  end

  logic [31:0]      mem [DEPTH_WORDS];

  // Request decode
  logic [31:0]      w_i_off, w_d_off;
  logic [IDX_W-1:0] w_i_idx, w_d_idx;
  logic             w_i_fault, w_d_fault, w_d_we;
  mem_size_e        w_d_size;
  logic [3:0]       w_st_be;
  logic [31:0]      w_st_word;

  assign w_d_size  = mem_size_e'(d_size);
  assign w_i_off   = i_address - START_ADDR;
  assign w_d_off   = d_address - START_ADDR;
  assign w_i_idx   = IDX_W'(w_i_off >> 2);
  assign w_d_idx   = IDX_W'(w_d_off >> 2);
  assign w_i_fault = mem_access_fault(i_address, START_ADDR, 32'(DEPTH_BYTES), MEM_SIZE_W);
  assign w_d_fault = mem_access_fault(d_address, START_ADDR, 32'(DEPTH_BYTES), w_d_size);
  assign w_d_we    = d_valid & d_read_write & ~w_d_fault;

  logic [31:0] w_unused_st_load;

  mem_lane_align u_store_align (
    .i_offset     (d_address[1:0]),
    .i_size       (d_size),
    .i_unsigned   (1'b0),
    .i_store_data (d_data_in),
    .i_load_word  (32'h0),
    .o_byte_en    (w_st_be),
    .o_store_word (w_st_word),
    .o_load_data  (w_unused_st_load)
  );

`ifdef FETCH_BYPASS_EN
  // Post-store view of the word being written this cycle.
  logic [31:0] w_bypass_word;
  always_comb begin
    w_bypass_word = mem[w_d_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_st_be[b]) w_bypass_word[8*b +: 8] = w_st_word[8*b +: 8];
    end
  end
`endif

  // Array and its read registers
  logic [31:0] r_i_word, r_d_word;

  // NOTE: the array and its read-data registers have no reset: RAM contents
  // survive reset, and the registers are qualified by the reset valid bits.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking, so both reads below see the pre-edge array even
    // when the write in this block targets the same word.
    r_i_word <= mem[w_i_idx];
`ifdef FETCH_BYPASS_EN
    if (w_d_we && (w_d_idx == w_i_idx)) r_i_word <= w_bypass_word;
`endif
    r_d_word <= mem[w_d_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_d_we && w_st_be[b]) mem[w_d_idx][8*b +: 8] <= w_st_word[8*b +: 8];
    end
  end

  // Response stage 1: valid tracking and load-lane context
  logic       r_i_v1, r_i_f1;
  logic       r_d_v1, r_d_f1, r_d_ld1, r_d_uns1;
  logic [1:0] r_d_off1, r_d_size1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_i_v1    <= 1'b0;
      r_i_f1    <= 1'b0;
      r_d_v1    <= 1'b0;
      r_d_f1    <= 1'b0;
      r_d_ld1   <= 1'b0;
      r_d_uns1  <= 1'b0;
      r_d_off1  <= 2'b00;
      r_d_size1 <= 2'b00;
    end else begin
      r_i_v1    <= i_valid;
      r_i_f1    <= i_valid & w_i_fault;
      r_d_v1    <= d_valid;
      r_d_f1    <= d_valid & w_d_fault;
      r_d_ld1   <= d_valid & ~d_read_write;
      r_d_uns1  <= d_unsigned;
      r_d_off1  <= d_address[1:0];
      r_d_size1 <= d_size;
    end
  end

  logic [31:0] w_ld_data, w_i_data1, w_d_data1;
  logic [3:0]  w_unused_ld_be;
  logic [31:0] w_unused_ld_word;

  mem_lane_align u_load_align (
    .i_offset     (r_d_off1),
    .i_size       (r_d_size1),
    .i_unsigned   (r_d_uns1),
    .i_store_data (32'h0),
    .i_load_word  (r_d_word),
    .o_byte_en    (w_unused_ld_be),
    .o_store_word (w_unused_ld_word),
    .o_load_data  (w_ld_data)
  );

  // Data is forced to zero unless this is a valid, non-faulting read.
  assign w_i_data1 = (r_i_v1 && !r_i_f1) ? r_i_word : 32'h0;
  assign w_d_data1 = (r_d_v1 && r_d_ld1 && !r_d_f1) ? w_ld_data : 32'h0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic        r_i_v2, r_i_f2, r_d_v2, r_d_f2;
    logic [31:0] r_i_d2, r_d_d2;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_i_v2 <= 1'b0;
        r_i_f2 <= 1'b0;
        r_i_d2 <= 32'h0;
        r_d_v2 <= 1'b0;
        r_d_f2 <= 1'b0;
        r_d_d2 <= 32'h0;
      end else begin
        r_i_v2 <= r_i_v1;
        r_i_f2 <= r_i_f1;
        r_i_d2 <= w_i_data1;
        r_d_v2 <= r_d_v1;
        r_d_f2 <= r_d_f1;
        r_d_d2 <= w_d_data1;
      end
    end

    assign i_rvalid   = r_i_v2;
    assign i_fault    = r_i_f2;
    assign i_data_out = r_i_d2;
    assign d_rvalid   = r_d_v2;
    assign d_fault    = r_d_f2;
    assign d_data_out = r_d_d2;
  end else begin : g_lat1
    assign i_rvalid   = r_i_v1;
    assign i_fault    = r_i_f1;
    assign i_data_out = w_i_data1;
    assign d_rvalid   = r_d_v1;
    assign d_fault    = r_d_f1;
    assign d_data_out = w_d_data1;
  end

endmodule

// File: tb/tb_unified_memory.sv
// -----------------------------------------------------------------------------
// tb_unified_memory
// Drives one request schedule into two unified_memory instances
// (READ_LATENCY = 1 and 2) sharing all inputs. Outputs of both are logged
// once per cycle on the falling edge; afterwards every expected response is
// looked up at request slot + latency and compared with hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unified_memory;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] DEPTH = 32'd1048576;
  localparam int          LOGN  = 256;
  localparam logic [1:0]  SZ_B  = 2'b00;
  localparam logic [1:0]  SZ_H  = 2'b01;
  localparam logic [1:0]  SZ_W  = 2'b10;
  localparam logic [1:0]  SZ_X  = 2'b11;

`ifdef FETCH_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_FETCH = 32'h2222_2222;
`else
  localparam logic [31:0] SAME_CYCLE_FETCH = 32'h1111_1111;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_address = 32'h0;
  logic        d_valid = 1'b0;
  logic [31:0] d_address = 32'h0;
  logic        d_read_write = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_data_in = 32'h0;

  logic        l1_i_rvalid, l1_i_fault, l1_d_rvalid, l1_d_fault;
  logic [31:0] l1_i_data, l1_d_data;
  logic        l2_i_rvalid, l2_i_fault, l2_d_rvalid, l2_d_fault;
  logic [31:0] l2_i_data, l2_d_data;

  unified_memory #(.READ_LATENCY(1)) u_lat1 (
    .clock(clock), .reset_n(reset_n),
    .i_valid(i_valid), .i_address(i_address),
    .i_rvalid(l1_i_rvalid), .i_data_out(l1_i_data), .i_fault(l1_i_fault),
    .d_valid(d_valid), .d_address(d_address), .d_read_write(d_read_write),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_data_in(d_data_in),
    .d_rvalid(l1_d_rvalid), .d_data_out(l1_d_data), .d_fault(l1_d_fault)
  );

  unified_memory #(.READ_LATENCY(2)) u_lat2 (
    .clock(clock), .reset_n(reset_n),
    .i_valid(i_valid), .i_address(i_address),
    .i_rvalid(l2_i_rvalid), .i_data_out(l2_i_data), .i_fault(l2_i_fault),
    .d_valid(d_valid), .d_address(d_address), .d_read_write(d_read_write),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_data_in(d_data_in),
    .d_rvalid(l2_d_rvalid), .d_data_out(l2_d_data), .d_fault(l2_d_fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        iv;
    logic [31:0] id;
    logic        ifl;
    logic        dv;
    logic [31:0] dd;
    logic        dfl;
  } resp_t;

  resp_t rlog [2][LOGN];
  int    edge_cnt = 0;
  int    n_vec = 0;
  int    n_miss = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    if (edge_cnt < LOGN) begin
      rlog[0][edge_cnt] <= '{l1_i_rvalid, l1_i_data, l1_i_fault, l1_d_rvalid, l1_d_data, l1_d_fault};
      rlog[1][edge_cnt] <= '{l2_i_rvalid, l2_i_data, l2_i_fault, l2_d_rvalid, l2_d_data, l2_d_fault};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus (each call occupies one cycle slot) ----------
  task automatic drive(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da, input logic rw,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                       output int slot);
    i_valid = iv;  i_address = ia;
    d_valid = dv;  d_address = da;  d_read_write = rw;
    d_size = sz;   d_unsigned = uns; d_data_in = wd;
    slot = edge_cnt;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    int s;
    for (int j = 0; j < n; j++) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, SZ_B, 1'b0, 32'h0, s);
  endtask

  task automatic fetch(input logic [31:0] a, output int slot);
    drive(1'b1, a, 1'b0, 32'h0, 1'b0, SZ_B, 1'b0, 32'h0, slot);
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                       output int slot);
    drive(1'b0, 32'h0, 1'b1, a, 1'b1, sz, 1'b0, wd, slot);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                      output int slot);
    drive(1'b0, 32'h0, 1'b1, a, 1'b0, sz, uns, 32'h0, slot);
  endtask

  // ---------------- response checks against the log ----------------------
  task automatic expect_i(input string tag, input int slot,
                          input logic [31:0] data, input logic fault);
    for (int k = 0; k < 2; k++) begin
      resp_t r;
      r = rlog[k][slot + k + 1];
      check($sformatf("%s/L%0d i_rvalid", tag, k + 1), {31'h0, r.iv}, 32'h1);
      check($sformatf("%s/L%0d i_data", tag, k + 1), r.id, data);
      check($sformatf("%s/L%0d i_fault", tag, k + 1), {31'h0, r.ifl}, {31'h0, fault});
    end
  endtask

  task automatic expect_d(input string tag, input int slot,
                          input logic [31:0] data, input logic fault);
    for (int k = 0; k < 2; k++) begin
      resp_t r;
      r = rlog[k][slot + k + 1];
      check($sformatf("%s/L%0d d_rvalid", tag, k + 1), {31'h0, r.dv}, 32'h1);
      check($sformatf("%s/L%0d d_data", tag, k + 1), r.dd, data);
      check($sformatf("%s/L%0d d_fault", tag, k + 1), {31'h0, r.dfl}, {31'h0, fault});
    end
  endtask

  // All outputs of instance k idle at log index idx.
  task automatic expect_quiet(input string tag, input int k, input int idx);
    resp_t r;
    r = rlog[k][idx];
    check($sformatf("%s/L%0d flags", tag, k + 1), {28'h0, r.iv, r.ifl, r.dv, r.dfl}, 32'h0);
    check($sformatf("%s/L%0d i_data", tag, k + 1), r.id, 32'h0);
    check($sformatf("%s/L%0d d_data", tag, k + 1), r.dd, 32'h0);
  endtask

  // ---------------- main sequence ----------------------------------------
  logic [31:0] init_words [10] = '{32'hDEAD_BEEF, 32'hAAAA_AAAA, 32'h0BAD_C0DE, 32'h1357_9BDF,
                                   32'h1111_1111, 32'h2468_ACE0, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                                   32'h5A5A_A5A5, 32'h7654_3210};

  int s_rst, s_pre, s_post, s_st0, s_top;
  int s_str [10];
  int s_sb, s_lbs, s_lbu, s_lw0, s_lh2, s_sh, s_lw1, s_lhu;
  int s_f_lh, s_f_sh, s_f_sw, s_f_sx, s_f_ilo, s_f_imis, s_f_lhi, s_f_shi, s_chk0, s_chk1, s_ltop;
  int s_bp, s_bp_next, s_bp_load;
  int s_tmp;

  initial begin
    @(negedge clock);

    // Requests during reset must be ignored.
    drive(1'b1, BASE, 1'b1, BASE, 1'b0, SZ_W, 1'b0, 32'h0, s_rst);
    drive(1'b1, BASE, 1'b1, BASE, 1'b0, SZ_W, 1'b0, 32'h0, s_tmp);
    idle(1);
    reset_n = 1'b1;
    idle(1);

    // Preload through the data port.
    for (int k = 0; k < 10; k++) begin
      store(BASE + 32'(4 * k), SZ_W, init_words[k], s_tmp);
      if (k == 0) s_st0 = s_tmp;
    end
    store(BASE + DEPTH - 32'd4, SZ_W, 32'h0BAD_F00D, s_top);
    idle(2);

    // Reset while a fetch response is in flight.
    fetch(BASE, s_pre);
    i_valid = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    fetch(BASE, s_post);
    idle(2);

    // Ten back-to-back fetches.
    for (int k = 0; k < 10; k++) fetch(BASE + 32'(4 * k), s_str[k]);
    idle(3);

    // Byte store then signed/unsigned loads on the following cycles.
    store(BASE + 32'd3, SZ_B, 32'h1234_5680, s_sb);
    load(BASE + 32'd3, SZ_B, 1'b0, s_lbs);
    load(BASE + 32'd3, SZ_B, 1'b1, s_lbu);
    load(BASE, SZ_W, 1'b1, s_lw0);
    load(BASE + 32'd2, SZ_H, 1'b0, s_lh2);

    // Half store into the upper lane.
    store(BASE + 32'd6, SZ_H, 32'hFFFF_1234, s_sh);
    load(BASE + 32'd4, SZ_W, 1'b0, s_lw1);
    load(BASE + 32'd4, SZ_H, 1'b1, s_lhu);
    idle(1);

    // Faults, then confirm memory untouched.
    load(BASE + 32'd1, SZ_H, 1'b0, s_f_lh);
    store(BASE + 32'd1, SZ_H, 32'h0000_7777, s_f_sh);
    store(BASE + 32'd2, SZ_W, 32'h5555_5555, s_f_sw);
    store(BASE, SZ_X, 32'h6666_6666, s_f_sx);
    fetch(BASE - 32'd4, s_f_ilo);
    fetch(BASE + 32'd2, s_f_imis);
    load(BASE + DEPTH, SZ_W, 1'b0, s_f_lhi);
    store(BASE + DEPTH, SZ_W, 32'h9999_9999, s_f_shi);
    load(BASE, SZ_W, 1'b0, s_chk0);
    load(BASE + 32'd4, SZ_W, 1'b0, s_chk1);
    load(BASE + DEPTH - 32'd4, SZ_W, 1'b0, s_ltop);
    idle(1);

    // Same-cycle fetch and store to one word.
    drive(1'b1, BASE + 32'h10, 1'b1, BASE + 32'h10, 1'b1, SZ_W, 1'b0, 32'h2222_2222, s_bp);
    fetch(BASE + 32'h10, s_bp_next);
    load(BASE + 32'h10, SZ_W, 1'b0, s_bp_load);
    idle(4);

    // ---------------- evaluate ----------------
    for (int k = 0; k < 2; k++) begin
      expect_quiet("reset_hold_a", k, s_rst + 1);
      expect_quiet("reset_hold_b", k, s_rst + 2);
    end
    expect_d("store_ack", s_st0, 32'h0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      expect_quiet("reset_drop_a", k, s_pre + 2);
      expect_quiet("reset_drop_b", k, s_pre + 3);
      expect_quiet("reset_drop_c", k, s_pre + 4);
      expect_quiet("post_reset_early", k, s_post + k);
    end
    expect_i("post_reset_fetch", s_post, 32'hDEAD_BEEF, 1'b0);

    for (int k = 0; k < 10; k++)
      expect_i($sformatf("stream%0d", k), s_str[k], init_words[k], 1'b0);
    for (int k = 0; k < 2; k++) begin
      expect_quiet("stream_before", k, s_str[0] + k);
      expect_quiet("stream_after", k, s_str[9] + k + 2);
    end

    expect_d("byte_store", s_sb, 32'h0, 1'b0);
    expect_d("byte_signed", s_lbs, 32'hFFFF_FF80, 1'b0);
    expect_d("byte_unsigned", s_lbu, 32'h0000_0080, 1'b0);
    expect_d("byte_word", s_lw0, 32'h80AD_BEEF, 1'b0);
    expect_d("half_signed", s_lh2, 32'hFFFF_80AD, 1'b0);
    expect_d("half_store", s_sh, 32'h0, 1'b0);
    expect_d("half_word", s_lw1, 32'h1234_AAAA, 1'b0);
    expect_d("half_unsigned", s_lhu, 32'h0000_AAAA, 1'b0);

    expect_d("fault_half_ld", s_f_lh, 32'h0, 1'b1);
    expect_d("fault_half_st", s_f_sh, 32'h0, 1'b1);
    expect_d("fault_word_st", s_f_sw, 32'h0, 1'b1);
    expect_d("fault_size11", s_f_sx, 32'h0, 1'b1);
    expect_i("fault_fetch_low", s_f_ilo, 32'h0, 1'b1);
    expect_i("fault_fetch_mis", s_f_imis, 32'h0, 1'b1);
    expect_d("fault_load_high", s_f_lhi, 32'h0, 1'b1);
    expect_d("fault_store_high", s_f_shi, 32'h0, 1'b1);
    expect_d("unchanged_w0", s_chk0, 32'h80AD_BEEF, 1'b0);
    expect_d("unchanged_w1", s_chk1, 32'h1234_AAAA, 1'b0);
    expect_d("last_word", s_ltop, 32'h0BAD_F00D, 1'b0);

    expect_i("same_cycle_fetch", s_bp, SAME_CYCLE_FETCH, 1'b0);
    expect_d("same_cycle_store", s_bp, 32'h0, 1'b0);
    expect_i("next_cycle_fetch", s_bp_next, 32'h2222_2222, 1'b0);
    expect_d("next_cycle_load", s_bp_load, 32'h2222_2222, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
